// File: rtl/mc_control_unit_if.sv
// rtl/mc_control_unit_if.sv - control unit <-> datapath signal bundle
interface mc_control_unit_if;
    logic [5:0] opcode;
    logic       zero;
    logic       sign;
    logic       PCWre;
    logic       IRWre;
    logic       ExtSel;
    logic       ALUSrcB;
    logic [2:0] ALUOp;
    logic       RegWre;
    logic [1:0] RegDst;
    logic       WrRegDSrc;
    logic       DBDataSrc;
    logic       mRD;
    logic       mWR;
    logic [1:0] PCSrc;
    logic [2:0] state;

    modport master (
        input  opcode, zero, sign,
        output PCWre, IRWre, ExtSel, ALUSrcB, ALUOp, RegWre, RegDst,
               WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc, state
    );

    modport slave (
        output opcode, zero, sign,
        input  PCWre, IRWre, ExtSel, ALUSrcB, ALUOp, RegWre, RegDst,
               WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc, state
    );
endinterface

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle MIPS control FSM
module mc_control_unit #(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic                CLK,
    input  logic                Reset,
    mc_control_unit_if.master   bus
);
    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_L   = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLTI  = 6'b011100;
    localparam logic [5:0] OP_SW    = 6'b100110;
    localparam logic [5:0] OP_LW    = 6'b100111;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;

    state_t state_q, state_d;

    logic is_add, is_sub, is_addiu, is_and, is_andi, is_ori, is_slti;
    logic is_sw, is_lw, is_beq, is_bne, is_bltz, is_j, is_jr, is_jal;
    logic is_halt, is_illegal, is_branch, ends_in_id, br_taken;

    always_comb begin
        is_add   = 1'b0; is_sub  = 1'b0; is_addiu = 1'b0; is_and  = 1'b0;
        is_andi  = 1'b0; is_ori  = 1'b0; is_slti  = 1'b0; is_sw   = 1'b0;
        is_lw    = 1'b0; is_beq  = 1'b0; is_bne   = 1'b0; is_bltz = 1'b0;
        is_j     = 1'b0; is_jr   = 1'b0; is_jal   = 1'b0; is_illegal = 1'b0;
        is_halt  = (bus.opcode == HALT_OP);
        if (!is_halt) begin
            case (bus.opcode)
                OP_ADD:   is_add   = 1'b1;
                OP_SUB:   is_sub   = 1'b1;
                OP_ADDIU: is_addiu = 1'b1;
                OP_AND:   is_and   = 1'b1;
                OP_ANDI:  is_andi  = 1'b1;
                OP_ORI:   is_ori   = 1'b1;
                OP_SLTI:  is_slti  = 1'b1;
                OP_SW:    is_sw    = 1'b1;
                OP_LW:    is_lw    = 1'b1;
                OP_BEQ:   is_beq   = 1'b1;
                OP_BNE:   is_bne   = 1'b1;
                OP_BLTZ:  is_bltz  = 1'b1;
                OP_J:     is_j     = 1'b1;
                OP_JR:    is_jr    = 1'b1;
                OP_JAL:   is_jal   = 1'b1;
                default:  is_illegal = 1'b1;
            endcase
        end
        is_branch  = is_beq | is_bne | is_bltz;
        ends_in_id = is_j | is_jr | is_jal | is_illegal;
        br_taken   = (is_beq & bus.zero) | (is_bne & ~bus.zero) | (is_bltz & bus.sign);
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:     state_d = S_ID;
            S_ID: begin
                if (is_halt)                state_d = S_ID;
                else if (ends_in_id)        state_d = S_IF;
                else if (is_branch)         state_d = S_EXE_BR;
                else if (is_lw || is_sw)    state_d = S_EXE_LS;
                else                        state_d = S_EXE_AL;
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = is_lw ? S_WB_L : S_IF;
            default:  state_d = S_IF;
        endcase
    end

    // Everything is gated by Reset so the datapath sees all-zero controls
    // (including IRWre) for as long as reset is held.
    always_comb begin
        bus.PCWre     = 1'b0;
        bus.IRWre     = 1'b0;
        bus.ExtSel    = 1'b0;
        bus.ALUSrcB   = 1'b0;
        bus.ALUOp     = 3'b000;
        bus.RegWre    = 1'b0;
        bus.RegDst    = 2'b00;
        bus.WrRegDSrc = 1'b0;
        bus.DBDataSrc = 1'b0;
        bus.mRD       = 1'b0;
        bus.mWR       = 1'b0;
        bus.PCSrc     = 2'b00;
        bus.state     = state_q;
        if (Reset) begin
            bus.ExtSel = ~(is_andi | is_ori);
            bus.IRWre  = (state_q == S_IF);
            if (state_q != S_IF) begin
                bus.ALUSrcB   = is_addiu | is_andi | is_ori | is_slti | is_lw | is_sw;
                bus.WrRegDSrc = ~is_jal;
                bus.DBDataSrc = is_lw;
                if (is_sub || is_branch)              bus.ALUOp = 3'b001;
                else if (is_slti)                     bus.ALUOp = 3'b010;
                else if (is_and || is_andi)           bus.ALUOp = 3'b100;
                else if (is_ori)                      bus.ALUOp = 3'b101;
                if (is_add || is_sub || is_and)       bus.RegDst = 2'b10;
                else if (is_addiu || is_andi || is_ori || is_slti || is_lw)
                                                      bus.RegDst = 2'b01;
            end
            case (state_q)
                S_ID: begin
                    bus.PCWre  = ends_in_id;
                    bus.RegWre = is_jal;
                    if (is_j || is_jal)               bus.PCSrc = 2'b11;
                    else if (is_jr)                   bus.PCSrc = 2'b10;
                end
                S_EXE_BR: begin
                    bus.PCWre = 1'b1;
                    bus.PCSrc = br_taken ? 2'b01 : 2'b00;
                end
                S_MEM: begin
                    bus.mRD   = is_lw;
                    bus.mWR   = is_sw;
                    bus.PCWre = is_sw;
                end
                S_WB_L, S_WB_AL: begin
                    bus.PCWre  = 1'b1;
                    bus.RegWre = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
